// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding,
// default sample-count constants and counter sizing helpers.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } btn_state_t;

  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_LONG_TICKS     = 500;
  localparam int DEF_REPEAT_TICKS   = 100;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Pin synchroniser, polarity normalisation and tick-sampled debounce counter.
// rise/fall are combinational strobes for the cycle in which level toggles.
module pb_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pb,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_TICKS);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS);
  localparam logic            IDLE_PIN = ACTIVE_LOW;

  logic            sync1_reg;
  logic            sync2_reg;
  logic            raw;
  logic [DB_W-1:0] db_cnt_reg;
  logic [DB_W-1:0] db_cnt_next;
  logic            level_reg;
  logic            level_next;

  // Synchroniser resets to the idle pin value so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= IDLE_PIN;
      sync2_reg <= IDLE_PIN;
    end else begin
      sync1_reg <= pb;
      sync2_reg <= sync1_reg;
    end
  end

  assign raw = sync2_reg ^ ACTIVE_LOW;

  always_comb begin
    db_cnt_next = db_cnt_reg;
    level_next  = level_reg;
    if (tick) begin
      if (raw != level_reg) begin
        if (db_cnt_reg + 1'b1 == DB_LAST) begin
          level_next  = ~level_reg;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
    end else begin
      db_cnt_reg <= db_cnt_next;
      level_reg  <= level_next;
    end
  end

  assign level = level_reg;
  assign rise  = level_next & ~level_reg;
  assign fall  = ~level_next & level_reg;

endmodule

// File: rtl/button_conditioner.sv
// Debounced button with press/release/long-press pulses; auto-repeat in the
// held state is compiled in only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pb,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int                HOLD_W    = cnt_width(max_int(LONG_TICKS, REPEAT_TICKS));
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS);
`endif

  logic              rise;
  logic              fall;
  btn_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              press_reg, press_next;
  logic              release_reg, release_next;
  logic              long_reg, long_next;
  logic              repeat_next;

  pb_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .ACTIVE_LOW    (ACTIVE_LOW)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .pb   (pb),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;
    repeat_next   = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (rise) begin
          state_next    = PRESSED;
          press_next    = 1'b1;
          hold_cnt_next = '0;
        end
      end
      PRESSED: begin
        // A release always wins, so no long_press can share its cycle.
        if (fall) begin
          state_next    = RELEASED;
          release_next  = 1'b1;
          hold_cnt_next = '0;
        end else if (tick) begin
          if (hold_cnt_reg + 1'b1 == LONG_LAST) begin
            state_next    = HELD;
            long_next     = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
      end
      HELD: begin
        if (fall) begin
          state_next    = RELEASED;
          release_next  = 1'b1;
          hold_cnt_next = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (tick) begin
          if (hold_cnt_reg + 1'b1 == REP_LAST) begin
            repeat_next   = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_next    = RELEASED;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RELEASED;
      hold_cnt_reg <= '0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      long_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      long_reg     <= long_next;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  logic repeat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_reg <= 1'b0;
    end else begin
      repeat_reg <= repeat_next;
    end
  end

  assign repeat_pulse = repeat_reg;
`else
  logic unused_repeat;
  assign unused_repeat = repeat_next;
  assign repeat_pulse  = 1'b0;
`endif

  assign press         = press_reg;
  assign release_pulse = release_reg;
  assign long_press    = long_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised scoreboard bench for button_conditioner: an active-high and an
// active-low instance, each checked against a sample-count reference model.
module tb_button_conditioner;

  localparam int DEB    = 4;
  localparam int LONG   = 8;
  localparam int REP    = 3;
  localparam int PERIOD = 5;
  localparam int NCYC   = 6000;
  localparam int TICK_ALL_START = 5000;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int P_NONE = 0, P_PRESS = 1, P_REL = 2, P_LONG = 3, P_REP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] pin = 2'b00;
  logic       pb0, pb1;
  logic [1:0] lvl, prs, rel, lng, rpt;

  assign pb0 = pin[0];
  assign pb1 = ~pin[1];

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_TICKS(DEB), .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pb(pb0),
    .level(lvl[0]), .press(prs[0]), .release_pulse(rel[0]), .long_press(lng[0]), .repeat_pulse(rpt[0])
  );

  button_conditioner #(.DEBOUNCE_TICKS(DEB), .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pb(pb1),
    .level(lvl[1]), .press(prs[1]), .release_pulse(rel[1]), .long_press(lng[1]), .repeat_pulse(rpt[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    int inst;
    int pulse;
    int level;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   done = 1'b0;

  // Reference model: pressed level, run of disagreeing samples, ticks since press.
  int m_lvl[2], m_run[2], m_held[2], m_h1[2], m_h2[2];

  task automatic check(input string name, input int inst, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", name, inst, cyc, got, want);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_held[i] = 0; m_h1[i] = 0; m_h2[i] = 0;
    end
  endtask

  // One clk edge: the debouncer sees the pin as it was two edges earlier.
  task automatic model_step(input int i, input int p, input bit tk, output int pulse);
    int raw;
    pulse = P_NONE;
    raw = m_h2[i];
    m_h2[i] = m_h1[i];
    m_h1[i] = p;
    if (tk) begin
      if (raw != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_run[i] = 0;
          m_lvl[i] = 1 - m_lvl[i];
          m_held[i] = 0;
          pulse = (m_lvl[i] == 1) ? P_PRESS : P_REL;
        end
      end else begin
        m_run[i] = 0;
      end
      if (pulse == P_NONE && m_lvl[i] == 1) begin
        m_held[i]++;
        if (m_held[i] == LONG) pulse = P_LONG;
        else if (AUTO && m_held[i] > LONG && ((m_held[i] - LONG) % REP) == 0) pulse = P_REP;
      end
    end
  endtask

  function automatic int rand_ticks();
    case ($urandom_range(0, 5))
      0: return $urandom_range(1, 3);
      1: return 6;
      2: return 10;
      3: return 20;
      4: return 30 + $urandom_range(0, 15);
      default: return $urandom_range(4, 9);
    endcase
  endfunction

  // Directed opening for instance 0: clean press, bounce, short press, long hold.
  int script_val[12]   = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
  int script_ticks[12] = '{6, 20, 10, 1, 1, 1, 1, 10, 6, 10, 30, 10};

  initial begin
    int seg_val[2];
    int seg_left[2];
    int sidx;
    int rst_left;
    bit held_rst_done;
    bit in_reset;
    int pulse;
    exp_t e;
    seg_val[0] = 0; seg_val[1] = 0;
    seg_left[0] = 0; seg_left[1] = 0;
    sidx = 0;
    rst_left = 3;
    held_rst_done = 1'b0;
    model_reset();
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      if (!held_rst_done && rst_left == 0 && m_held[0] > LONG + 1) begin
        rst_left = 3;
        held_rst_done = 1'b1;
      end
      if (k == 3000) rst_left = 2;
      in_reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      for (int i = 0; i < 2; i++) begin
        if (seg_left[i] == 0) begin
          if (i == 0 && sidx < 12) begin
            seg_val[0] = script_val[sidx];
            seg_left[0] = script_ticks[sidx] * PERIOD;
            sidx++;
          end else begin
            seg_val[i] = 1 - seg_val[i];
            seg_left[i] = rand_ticks() * PERIOD + $urandom_range(0, 4);
          end
        end
        seg_left[i]--;
      end
      pin[0] = seg_val[0][0];
      pin[1] = seg_val[1][0];
      tick = (k >= TICK_ALL_START) ? 1'b1 : ((k % PERIOD) == PERIOD - 1);
      rst_n = !in_reset;
      for (int i = 0; i < 2; i++) begin
        if (in_reset) begin
          model_reset();
          pulse = P_NONE;
        end else begin
          model_step(i, seg_val[i], tick, pulse);
        end
        e.cycle = cyc + 1;
        e.inst  = i;
        e.pulse = pulse;
        e.level = in_reset ? 0 : m_lvl[i];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #5;
    done = 1'b1;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL leftover_expectations: got %0d queued, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor: compares each edge's outputs against the queued expectations.
  initial begin
    int   obs[2];
    int   nhigh[2];
    int   want_p[2];
    int   want_l[2];
    bit   have[2];
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      have[0] = 1'b0; have[1] = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
        e = exp_q.pop_front();
        check("stale_expectation", e.inst, cyc, e.cycle);
      end
      while (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
        e = exp_q.pop_front();
        have[e.inst] = 1'b1;
        want_p[e.inst] = e.pulse;
        want_l[e.inst] = e.level;
      end
      for (int i = 0; i < 2; i++) begin
        nhigh[i] = int'(prs[i]) + int'(rel[i]) + int'(lng[i]) + int'(rpt[i]);
        obs[i] = prs[i] ? P_PRESS : rel[i] ? P_REL : lng[i] ? P_LONG : rpt[i] ? P_REP : P_NONE;
        if (!have[i]) begin
          check("missing_expectation", i, 0, 1);
        end else begin
          check("level", i, int'(lvl[i]), want_l[i]);
          if (obs[i] != P_NONE || want_p[i] != P_NONE)
            check("pulse", i, obs[i], want_p[i]);
          if (nhigh[i] > 0)
            check("onehot", i, nhigh[i], 1);
        end
      end
    end
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Upstream conditioner for the board push-buttons and switches that drive the ping-pong counter's `flip` and `rst_n`. Synchronises a raw pin, debounces it on a slow sample strobe, and produces a clean level, single-cycle press/release pulses, a long-press pulse and optional auto-repeat pulses. All outputs are in the `clk` domain and are consumed directly by the counter's control inputs.

## Interface
- `DEBOUNCE_TICKS`, 4: consecutive disagreeing samples required to change the debounced level (≥1)
- `LONG_TICKS`, 500: held samples after press before `long_press` fires (≥1)
- `REPEAT_TICKS`, 100: sample period between `repeat` pulses after long press (≥1)
- `ACTIVE_LOW`, 0: 1 = pin reads 0 when pressed
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `tick`  in  1  sample strobe, one `clk` cycle wide (e.g. 1 ms refresh strobe)
- `pb`  in  1  raw, asynchronous button pin
- `level`  out  1  debounced pressed state (1 = pressed)
- `press`  out  1  one-cycle pulse on debounced press
- `release`  out  1  one-cycle pulse on debounced release
- `long_press`  out  1  one-cycle pulse when held `LONG_TICKS` samples
- `repeat`  out  1  one-cycle pulse every `REPEAT_TICKS` samples after `long_press`

## Operation
- Two-flop synchroniser on `pb` every `clk`; result normalised by `ACTIVE_LOW` to `raw` (1 = pressed).
- Debounce counter `db_cnt` advances only on `tick` cycles: `raw != level` → increment; `raw == level` → clear. When incremented value equals `DEBOUNCE_TICKS`, `level` toggles and `db_cnt` clears. Non-tick cycles hold everything.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED → PRESSED on level rise; `press`=1 that cycle; `hold_cnt` cleared.
  - PRESSED: `hold_cnt` increments per tick; on reaching `LONG_TICKS` → HELD, `long_press`=1, `hold_cnt` cleared.
  - HELD: `hold_cnt` increments per tick; on reaching `REPEAT_TICKS`, `repeat`=1, `hold_cnt` cleared (only with auto-repeat compiled in; otherwise `hold_cnt` frozen).
  - PRESSED/HELD → RELEASED on level fall; `release`=1; no `long_press`/`repeat` in that cycle.
- Counters sized `$clog2(N+1)`; never wrap, cleared on every state change.
- Glitch shorter than `DEBOUNCE_TICKS` samples: no output change.
- `tick` held high continuously: every cycle is a sample; behaviour still defined.

## Timing
- Reset values: `level`=0, all pulses 0, state RELEASED, counters 0, synchroniser flops at the not-pressed pin value.
- All outputs registered; change on the `clk` edge where the deciding `tick` is sampled.
- Pin-to-`level` latency: 2 `clk` (sync) + `DEBOUNCE_TICKS` ticks.
- `press`/`release` coincide with the `level` edge; `long_press` at tick `LONG_TICKS` after press; first `repeat` `REPEAT_TICKS` ticks after `long_press`.
- At most one pulse output high in any cycle.
- Reset asserted mid-press: immediate return to reset values, no `release` pulse. Button held through reset deassertion: `press` after `DEBOUNCE_TICKS` ticks.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: HELD generates periodic `repeat` as above.
- Not defined: `repeat` tied to 0, repeat counter logic removed; HELD waits for release only.

## Structure
- Package `btn_pkg`: FSM state encoding (RELEASED=2'd0, PRESSED=2'd1, HELD=2'd2), default tick constants.
- Sub-module `pb_debounce`: synchroniser, polarity normalisation and debounce counter; outputs `level` and one-cycle edge strobe. Top holds FSM and hold counter.

## Test plan
Bench: `DEBOUNCE_TICKS`=4, `LONG_TICKS`=8, `REPEAT_TICKS`=3, `tick` every 5 `clk`, `BTN_AUTOREPEAT_EN` defined.
- Clean press for 20 ticks then release → `press` once at tick 4 after sync, `level`=1, `long_press` at 8 ticks after press, `repeat` at +3, +6, +9 ticks, `release` once 4 ticks after pin falls.
- Pin bounces 1-0-1-0 per tick for 3 ticks then low → no `press`, `level` stays 0.
- Press held 6 ticks → `press` and `release` only; no `long_press`.
- `ACTIVE_LOW`=1, pin driven 0 for 10 ticks → `press` after 4 ticks; pin 1 at reset → no pulses.
- `rst_n` pulsed low while in HELD → all outputs 0 immediately, no `release`; pin still pressed → `press` 4 ticks after deassertion.
- Rebuild without `BTN_AUTOREPEAT_EN`, hold 30 ticks → exactly one `long_press`, `repeat` never 1.
